// File: rtl/eth_l3_csum_ctrl_if.sv
// Rx MAC byte stream plus the checksum verdict valid/ack holding register,
// grouped so the sequencer and its consumer share one bundle.
interface eth_l3_csum_ctrl_if;
   logic [7:0]  RxData;
   logic        RxValid;
   logic        RxStartFrm;
   logic        RxEndFrm;
   logic        CsAck;
   logic        CsValid;
   logic        CsIsIp;
   logic        CsOk;
   logic        CsTrunc;
   logic [15:0] CsResult;
   logic        CsOverrun;

   modport slave (
      input  RxData, RxValid, RxStartFrm, RxEndFrm, CsAck,
      output CsValid, CsIsIp, CsOk, CsTrunc, CsResult, CsOverrun
   );

   modport master (
      output RxData, RxValid, RxStartFrm, RxEndFrm, CsAck,
      input  CsValid, CsIsIp, CsOk, CsTrunc, CsResult, CsOverrun
   );
endinterface

// File: rtl/eth_l3_csum_ctrl.sv
// IPv4 header checksum sequencer: qualifies Rx frames as IPv4, sums the IHL-sized
// header in one's-complement arithmetic and posts one verdict per frame.
module eth_l3_csum_ctrl #(
   parameter logic [15:0] ETYPE_IPV4 = 16'h0800,
   parameter int          HDR_OFFSET = 14,
   parameter int          MIN_IHL    = 5
) (
   input  logic MRxClk,
   input  logic Reset,
   eth_l3_csum_ctrl_if.slave bus
);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_MAC   = 3'd1;
   localparam logic [2:0] ST_ETYPE = 3'd2;
   localparam logic [2:0] ST_HDR   = 3'd3;
   localparam logic [2:0] ST_TAIL  = 3'd4;

   localparam logic [15:0] ETYPE_HI_IDX = 16'(HDR_OFFSET - 2);
   localparam logic [15:0] HDR_BASE     = 16'(HDR_OFFSET);
   localparam logic [3:0]  MIN_IHL_L    = 4'(MIN_IHL);

   logic [2:0]  state_reg, state_next;
   logic [15:0] cnt_reg, cnt_next;
   logic [15:0] acc_reg, acc_next;
   logic [7:0]  hi_reg, hi_next;
   logic [5:0]  hdr_len_reg, hdr_len_next;
   logic        trunc_reg, trunc_next;
   logic        is_ip_reg, is_ip_next;

   logic        cs_valid_reg, cs_is_ip_reg, cs_ok_reg, cs_trunc_reg, cs_overrun_reg;
   logic [15:0] cs_result_reg;

   logic        post, post_ip;
   logic [16:0] sum17;
   logic [15:0] acc_sum;
   logic [15:0] hdr_off;
   logic [5:0]  hdr_len_cur;
   logic        hdr_last;

   // End-around carry keeps the running sum in one's-complement form.
   assign sum17   = {1'b0, acc_reg} + {1'b0, hi_reg, bus.RxData};
   assign acc_sum = sum17[15:0] + {15'd0, sum17[16]};

   // Byte counter already holds the index of the byte currently on RxData.
   assign hdr_off     = cnt_reg - HDR_BASE;
   assign hdr_len_cur = (hdr_off == 16'd0) ? {bus.RxData[3:0], 2'b00} : hdr_len_reg;
   assign hdr_last    = (hdr_off == ({10'd0, hdr_len_cur} - 16'd1));

   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      acc_next     = acc_reg;
      hi_next      = hi_reg;
      hdr_len_next = hdr_len_reg;
      trunc_next   = trunc_reg;
      is_ip_next   = is_ip_reg;
      post         = 1'b0;
      post_ip      = 1'b0;
      if (bus.RxValid) begin
         if (bus.RxStartFrm) begin
            // Start always restarts; with end in the same byte it is a 1-byte non-IP frame.
            cnt_next   = 16'd1;
            acc_next   = 16'h0000;
            trunc_next = 1'b0;
            is_ip_next = 1'b0;
            post       = bus.RxEndFrm;
            state_next = bus.RxEndFrm ? ST_IDLE : ST_MAC;
         end else if (state_reg != ST_IDLE) begin
            cnt_next = (cnt_reg == 16'hFFFF) ? cnt_reg : cnt_reg + 16'd1;
            case (state_reg)
               ST_MAC: begin
                  if (cnt_reg == ETYPE_HI_IDX) begin
                     hi_next    = bus.RxData;
                     state_next = ST_ETYPE;
                  end
               end
               ST_ETYPE: begin
                  if ({hi_reg, bus.RxData} == ETYPE_IPV4) begin
                     is_ip_next = 1'b1;
                     state_next = ST_HDR;
                  end else begin
                     state_next = ST_TAIL;
                  end
               end
               ST_HDR: begin
                  if (hdr_off == 16'd0) begin
                     hdr_len_next = hdr_len_cur;
                     hi_next      = bus.RxData;
                     if (bus.RxData[3:0] < MIN_IHL_L) begin
                        trunc_next = 1'b1;
                        state_next = ST_TAIL;
                     end
                  end else if (!hdr_off[0]) begin
                     hi_next = bus.RxData;
                  end else begin
                     acc_next = acc_sum;
                     if (hdr_last) state_next = ST_TAIL;
                  end
                  // Ending on the final (odd) header byte still completes the header.
                  if (bus.RxEndFrm && !(hdr_off[0] && hdr_last)) trunc_next = 1'b1;
               end
               default: ;
            endcase
            if (bus.RxEndFrm) begin
               post       = 1'b1;
               post_ip    = is_ip_reg;
               state_next = ST_IDLE;
            end
         end
      end
   end

   always_ff @(posedge MRxClk) begin
      if (Reset) begin
         state_reg   <= ST_IDLE;
         cnt_reg     <= 16'd0;
         acc_reg     <= 16'h0000;
         hi_reg      <= 8'h00;
         hdr_len_reg <= 6'd0;
         trunc_reg   <= 1'b0;
         is_ip_reg   <= 1'b0;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         acc_reg     <= acc_next;
         hi_reg      <= hi_next;
         hdr_len_reg <= hdr_len_next;
         trunc_reg   <= trunc_next;
         is_ip_reg   <= is_ip_next;
      end
   end

   // Holding register: a post into a full, unacknowledged register is dropped.
   always_ff @(posedge MRxClk) begin
      if (Reset) begin
         cs_valid_reg   <= 1'b0;
         cs_is_ip_reg   <= 1'b0;
         cs_ok_reg      <= 1'b0;
         cs_trunc_reg   <= 1'b0;
         cs_result_reg  <= 16'h0000;
         cs_overrun_reg <= 1'b0;
      end else begin
         cs_overrun_reg <= 1'b0;
         if (post) begin
            if (!cs_valid_reg || bus.CsAck) begin
               cs_valid_reg  <= 1'b1;
               cs_is_ip_reg  <= post_ip;
               cs_trunc_reg  <= post_ip & trunc_next;
               cs_ok_reg     <= post_ip & ~trunc_next & (acc_next == 16'hFFFF);
               cs_result_reg <= post_ip ? ~acc_next : 16'h0000;
            end else begin
               cs_overrun_reg <= 1'b1;
            end
         end else if (bus.CsAck) begin
            cs_valid_reg <= 1'b0;
         end
      end
   end

   assign bus.CsValid   = cs_valid_reg;
   assign bus.CsIsIp    = cs_is_ip_reg;
   assign bus.CsOk      = cs_ok_reg;
   assign bus.CsTrunc   = cs_trunc_reg;
   assign bus.CsResult  = cs_result_reg;
   assign bus.CsOverrun = cs_overrun_reg;

endmodule
